noc_flit_packetizer: RTL

//  Network-interface transmitter feeding a router's local input port. Accepts a

---
 rtl/noc_flit_packetizer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/noc_flit_packetizer.sv
// Network-interface flit transmitter: turns a packet request plus a payload
// stream into head/body/tail flits with credit-based flow control on two VCs.
module noc_flit_packetizer #(
    parameter int BUF_DEPTH = 4,
    parameter int LEN_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_dest_x,
    input  logic [7:0]       req_dest_y,
    input  logic [LEN_W-1:0] req_len,
    input  logic             pl_valid,
    output logic             pl_ready,
    input  logic [39:0]      pl_data,
    output logic             flit_valid,
    output logic [63:0]      flit_out,
    output logic [1:0]       flit_vc,
    input  logic [1:0]       credit_in,
    output logic             busy,
    output logic             credit_err
);
    localparam int              CW       = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0]   CRED_MAX = CW'(BUF_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HEAD = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;
    localparam logic [1:0] S_TAIL = 2'd3;

    localparam logic [2:0] T_HEAD = 3'b000;
    localparam logic [2:0] T_BODY = 3'b001;
    localparam logic [2:0] T_TAIL = 3'b010;

    typedef struct packed {
        logic [7:0]       dest_y;
        logic [7:0]       dest_x;
        logic [LEN_W-1:0] len;
    } pkt_req_t;

    logic [1:0]       state;
    pkt_req_t         req_q;
    logic [LEN_W-1:0] flits_left;
    logic [4:0]       pkt_id;
    logic             vc_lock;
    logic             cur_vc;
    logic             credit_avail;
    logic             send;
    logic [2:0]       ftype;
    logic [CW-1:0]    credit [2];
    logic [1:0]       cred_ok;
    logic [1:0]       cred_dec;
    logic [1:0]       cred_ovf;

    // Head picks the lowest VC with room; later flits stay on the locked VC.
    always_comb begin
        cur_vc       = vc_lock;
        credit_avail = 1'b0;
        ftype        = T_HEAD;
        case (state)
            S_HEAD: begin
                cur_vc       = ~cred_ok[0];
                credit_avail = |cred_ok;
            end
            S_BODY: begin
                credit_avail = cred_ok[vc_lock];
                ftype        = T_BODY;
            end
            S_TAIL: begin
                credit_avail = cred_ok[vc_lock];
                ftype        = T_TAIL;
            end
            default: ;
        endcase
    end

    assign send      = pl_valid & credit_avail & (state != S_IDLE);
    assign pl_ready  = send;
    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    genvar v;
    for (v = 0; v < 2; v++) begin : g_vc
        assign cred_ok[v]  = (credit[v] != '0);
        assign cred_dec[v] = send & (cur_vc == 1'(v));
        assign cred_ovf[v] = credit_in[v] & ~cred_dec[v] & (credit[v] == CRED_MAX);

        // A return and a send on the same VC in one cycle cancel out.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                credit[v] <= CRED_MAX;
            else if (cred_dec[v] & ~credit_in[v])
                credit[v] <= credit[v] - 1'b1;
            else if (credit_in[v] & ~cred_dec[v] & ~cred_ovf[v])
                credit[v] <= credit[v] + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            credit_err <= 1'b0;
        else if (|cred_ovf)
            credit_err <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            req_q      <= '0;
            flits_left <= '0;
            pkt_id     <= '0;
            vc_lock    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    req_q.dest_x <= req_dest_x;
                    req_q.dest_y <= req_dest_y;
                    req_q.len    <= (req_len < LEN_W'(2)) ? LEN_W'(2) : req_len;
                    state        <= S_HEAD;
                end
                S_HEAD: if (send) begin
                    vc_lock    <= cur_vc;
                    flits_left <= req_q.len - 1'b1;
                    state      <= (req_q.len - 1'b1 > LEN_W'(1)) ? S_BODY : S_TAIL;
                end
                S_BODY: if (send) begin
                    flits_left <= flits_left - 1'b1;
                    if (flits_left == LEN_W'(2))
                        state <= S_TAIL;
                end
                S_TAIL: if (send) begin
                    pkt_id <= pkt_id + 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_valid <= 1'b0;
            flit_out   <= '0;
            flit_vc    <= '0;
        end else begin
            flit_valid <= send;
            if (send) begin
                flit_out <= {req_q.dest_y, req_q.dest_x, ftype, pkt_id, pl_data};
                flit_vc  <= {1'b0, cur_vc};
            end
        end
    end
endmodule
